// File: rtl/regfile_pkg.sv
// Shared defaults, sweep FSM state type and depth helper for the scoreboarded register file.
package regfile_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int REG_W_DEF  = 5;
   localparam int NREGS_DEF  = 2**REG_W_DEF;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } rf_state_e;

   function automatic int nregs(input int reg_w);
      return 2**reg_w;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared by writeback.
// REGFILE_BYPASS_EN lets same-cycle clearing writes hide the pending bit from stall and busy.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int REG_W  = REG_W_DEF,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    run,
   input  logic                    iss_valid,
   input  logic [REG_W-1:0]        iss_rd,
   input  logic [NUM_WR-1:0]       wr_en,
   input  logic [NUM_WR*REG_W-1:0] wr_addr,
   input  logic [NUM_RD*REG_W-1:0] rd_addr,
   output logic                    iss_stall,
   output logic [NUM_RD-1:0]       rd_busy
);

   localparam int NREGS = nregs(REG_W);

   logic [NREGS-1:0] pending;
   logic [NREGS-1:0] clr;
   logic [NREGS-1:0] set_v;
   logic [NREGS-1:0] pend_eff;

   always_comb begin
      clr       = '0;
      set_v     = '0;
      rd_busy   = '0;
      iss_stall = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
         if (run && wr_en[j]) clr[wr_addr[j*REG_W +: REG_W]] = 1'b1;
      end
`ifdef REGFILE_BYPASS_EN
      pend_eff = pending & ~clr;
`else
      pend_eff = pending;
`endif
      iss_stall = run && iss_valid && pend_eff[iss_rd];
      if (run && iss_valid && !iss_stall && (iss_rd != '0)) set_v[iss_rd] = 1'b1;
      for (int k = 0; k < NUM_RD; k++) begin
         rd_busy[k] = run && (rd_addr[k*REG_W +: REG_W] != '0)
                      && pend_eff[rd_addr[k*REG_W +: REG_W]];
      end
   end

   // Set is applied after clear so a same-cycle issue wins over writeback.
   always_ff @(posedge clk) begin
      if (reset || !run) begin
         pending <= '0;
      end else begin
         pending    <= (pending & ~clr) | set_v;
         pending[0] <= 1'b0;
      end
   end

endmodule

// File: rtl/regfile_scb.sv
// Multi-port register file with post-reset clearing sweep and pending-write scoreboard.
// Optional REGFILE_BYPASS_EN: same-cycle write-to-read forwarding.
module regfile_scb
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_W  = REG_W_DEF,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     ready,
   input  logic [NUM_RD*REG_W-1:0]  rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*REG_W-1:0]  wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic                     iss_valid,
   input  logic [REG_W-1:0]         iss_rd,
   output logic                     iss_stall
);

   // state | meaning
   // INIT  | sweep clears mem[ptr] each cycle; ports ignored, outputs zero
   // RUN   | normal operation, ready=1

   localparam int NREGS = nregs(REG_W);

   logic [DATA_W-1:0] mem [NREGS];
   rf_state_e         state, state_nx;
   logic [REG_W-1:0]  ptr, ptr_nx;
   logic              run;

   assign run   = (state == RUN);
   assign ready = run;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= INIT;
         ptr   <= '0;
      end else begin
         state <= state_nx;
         ptr   <= ptr_nx;
      end
   end

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      case (state)
         INIT: begin
            ptr_nx = ptr + 1'b1;
            if (ptr == {REG_W{1'b1}}) state_nx = RUN;
         end
         RUN: ;
         default: state_nx = INIT;
      endcase
   end

   // Later ports overwrite earlier ones, giving the highest index priority.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == INIT) begin
            mem[ptr] <= '0;
         end else begin
            for (int j = 0; j < NUM_WR; j++) begin
               if (wr_en[j] && (wr_addr[j*REG_W +: REG_W] != '0))
                  mem[wr_addr[j*REG_W +: REG_W]] <= wr_data[j*DATA_W +: DATA_W];
            end
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         if (run && (rd_addr[k*REG_W +: REG_W] != '0)) begin
            rd_data[k*DATA_W +: DATA_W] = mem[rd_addr[k*REG_W +: REG_W]];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NUM_WR; j++) begin
               if (wr_en[j] && (wr_addr[j*REG_W +: REG_W] == rd_addr[k*REG_W +: REG_W]))
                  rd_data[k*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
            end
`endif
         end
      end
   end

   regfile_scoreboard #(
      .REG_W  (REG_W),
      .NUM_RD (NUM_RD),
      .NUM_WR (NUM_WR)
   ) u_scoreboard (
      .clk       (clk),
      .reset     (reset),
      .run       (run),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .rd_addr   (rd_addr),
      .iss_stall (iss_stall),
      .rd_busy   (rd_busy)
   );

endmodule

// File: tb/tb_regfile_scb.sv
// Bench for regfile_scb: vector table through a scoreboard queue, plus reset/sweep sequences.
module tb_regfile_scb;

   logic        clk = 1'b0;
   logic        reset;
   logic        ready;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic        iss_stall;

   int nvec = 0;
   int nerr = 0;

   regfile_scb dut (
      .clk       (clk),
      .reset     (reset),
      .ready     (ready),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_busy   (rd_busy),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .iss_stall (iss_stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  we;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic        iv;
      logic [4:0]  ir;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [1:0]  busy;
      logic        stall;
      logic [31:0] d0b;
      logic [31:0] d1b;
      logic [1:0]  busyb;
      logic        stallb;
   } vec_t;

   typedef struct {
      int          idx;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [1:0]  busy;
      logic        stall;
   } exp_t;

   vec_t vt[18];
   exp_t q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      wr_en = '0; wr_addr = '0; wr_data = '0;
      iss_valid = 1'b0; iss_rd = '0;
   endtask

   task automatic count_sweep(output int n);
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         if (ready) break;
         if (n == 0) begin
            chk("init_rd_data0", {32'h0, rd_data[31:0]}, 64'h0);
            chk("init_rd_busy0", {63'h0, rd_busy[0]}, 64'h0);
            chk("init_iss_stall", {63'h0, iss_stall}, 64'h0);
         end
         n++;
      end
      idle();
   endtask

   task automatic scan_zero(input string tag);
      for (int i = 0; i < 32; i++) begin
         rd_addr = {5'(i), 5'(i)};
         @(negedge clk);
         chk({tag, "_data"}, {32'h0, rd_data[31:0]}, 64'h0);
         chk({tag, "_busy"}, {62'h0, rd_busy}, 64'h0);
      end
   endtask

   initial begin
      int   n;
      exp_t e;

      //          we    wa0  wd0           wa1  wd1     iv    ir   ra0  ra1  d0            d1            busy   st    d0b           d1b           busyb  stb
      vt[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 5'd0, 32'h0,        32'h0,        2'b00, 1'b0, 32'hDEADBEEF, 32'h0,        2'b00, 1'b0};
      vt[1]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 5'd7, 32'hDEADBEEF, 32'h0,        2'b00, 1'b0, 32'hDEADBEEF, 32'h0,        2'b00, 1'b0};
      vt[2]  = '{2'b11, 5'd7, 32'h11,       5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd5, 32'h0,        32'hDEADBEEF, 2'b00, 1'b0, 32'h22,       32'hDEADBEEF, 2'b00, 1'b0};
      vt[3]  = '{2'b01, 5'd0, 32'hFFFF,     5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 5'd0, 32'h22,       32'h0,        2'b00, 1'b0, 32'h22,       32'h0,        2'b00, 1'b0};
      vt[4]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 5'd7, 32'h0,        32'h22,       2'b00, 1'b0, 32'h0,        32'h22,       2'b00, 1'b0};
      vt[5]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd9, 5'd9, 5'd0, 32'h0,        32'h0,        2'b00, 1'b0, 32'h0,        32'h0,        2'b00, 1'b0};
      vt[6]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd9, 5'd9, 5'd0, 32'h0,        32'h0,        2'b01, 1'b1, 32'h0,        32'h0,        2'b01, 1'b1};
      vt[7]  = '{2'b10, 5'd0, 32'h0,        5'd9, 32'h99, 1'b0, 5'd0, 5'd9, 5'd0, 32'h0,        32'h0,        2'b01, 1'b0, 32'h99,       32'h0,        2'b00, 1'b0};
      vt[8]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 5'd0, 32'h99,       32'h0,        2'b00, 1'b0, 32'h99,       32'h0,        2'b00, 1'b0};
      vt[9]  = '{2'b01, 5'd3, 32'h33,       5'd0, 32'h0,  1'b1, 5'd3, 5'd3, 5'd0, 32'h0,        32'h0,        2'b00, 1'b0, 32'h33,       32'h0,        2'b00, 1'b0};
      vt[10] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd3, 5'd0, 32'h33,       32'h0,        2'b01, 1'b0, 32'h33,       32'h0,        2'b01, 1'b0};
      vt[11] = '{2'b01, 5'd3, 32'h44,       5'd0, 32'h0,  1'b1, 5'd3, 5'd3, 5'd0, 32'h33,       32'h0,        2'b01, 1'b1, 32'h44,       32'h0,        2'b00, 1'b0};
      vt[12] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd3, 5'd0, 32'h44,       32'h0,        2'b00, 1'b0, 32'h44,       32'h0,        2'b01, 1'b0};
      vt[13] = '{2'b01, 5'd3, 32'h45,       5'd0, 32'h0,  1'b0, 5'd0, 5'd3, 5'd4, 32'h44,       32'h0,        2'b00, 1'b0, 32'h45,       32'h0,        2'b00, 1'b0};
      vt[14] = '{2'b01, 5'd4, 32'h55,       5'd0, 32'h0,  1'b0, 5'd0, 5'd4, 5'd3, 32'h0,        32'h45,       2'b00, 1'b0, 32'h55,       32'h45,       2'b00, 1'b0};
      vt[15] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd4, 5'd4, 5'd3, 32'h55,       32'h45,       2'b00, 1'b0, 32'h55,       32'h45,       2'b00, 1'b0};
      vt[16] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd10,5'd4, 5'd10,32'h55,       32'h0,        2'b01, 1'b0, 32'h55,       32'h0,        2'b01, 1'b0};
      vt[17] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd4, 5'd10,32'h55,       32'h0,        2'b11, 1'b0, 32'h55,       32'h0,        2'b11, 1'b0};

      idle();
      rd_addr = '0;
      reset   = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      count_sweep(n);
      chk("sweep_len_first", 64'(n), 64'd32);
      scan_zero("post_sweep");

      foreach (vt[i]) begin
         @(posedge clk); #1;
         wr_en     = vt[i].we;
         wr_addr   = {vt[i].wa1, vt[i].wa0};
         wr_data   = {vt[i].wd1, vt[i].wd0};
         iss_valid = vt[i].iv;
         iss_rd    = vt[i].ir;
         rd_addr   = {vt[i].ra1, vt[i].ra0};
`ifdef REGFILE_BYPASS_EN
         q.push_back('{i, vt[i].d0b, vt[i].d1b, vt[i].busyb, vt[i].stallb});
`else
         q.push_back('{i, vt[i].d0, vt[i].d1, vt[i].busy, vt[i].stall});
`endif
         @(negedge clk);
         e = q.pop_front();
         chk($sformatf("v%0d_rd_data0", e.idx), {32'h0, rd_data[31:0]}, {32'h0, e.d0});
         chk($sformatf("v%0d_rd_data1", e.idx), {32'h0, rd_data[63:32]}, {32'h0, e.d1});
         chk($sformatf("v%0d_rd_busy", e.idx), {62'h0, rd_busy}, {62'h0, e.busy});
         chk($sformatf("v%0d_iss_stall", e.idx), {63'h0, iss_stall}, {63'h0, e.stall});
      end

      // Reset in RUN with x4=0x55 and x4/x10 pending; INIT must ignore writes and issues.
      @(posedge clk); #1;
      idle();
      reset     = 1'b1;
      rd_addr   = {5'd10, 5'd4};
      wr_en     = 2'b01;
      wr_addr   = {5'd0, 5'd6};
      wr_data   = {32'h0, 32'h66};
      iss_valid = 1'b1;
      iss_rd    = 5'd4;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("ready_in_reset_init", {63'h0, ready}, 64'h0);
      count_sweep(n);
      chk("sweep_len_run_reset", 64'(n), 64'd32);
      scan_zero("run_reset");

      // Reset again mid-sweep at ptr=20; x25 written beforehand must still end up zero.
      @(posedge clk); #1;
      wr_en   = 2'b01;
      wr_addr = {5'd0, 5'd25};
      wr_data = {32'h0, 32'h77};
      @(posedge clk); #1;
      idle();
      rd_addr = {5'd0, 5'd25};
      @(negedge clk);
      chk("x25_written", {32'h0, rd_data[31:0]}, 64'h77);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("ready_mid_sweep", {63'h0, ready}, 64'h0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      count_sweep(n);
      chk("sweep_len_mid_reset", 64'(n), 64'd32);
      rd_addr = {5'd4, 5'd25};
      @(negedge clk);
      chk("x25_cleared", {32'h0, rd_data[31:0]}, 64'h0);
      chk("x4_cleared", {32'h0, rd_data[63:32]}, 64'h0);
      chk("busy_cleared", {62'h0, rd_busy}, 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
